dht11_uart_report: RTL and testbench

Downstream consumer of the DHT11 controller: captures each `humidity`/`temperature` sample on its `data_valid` pulse and transmits it as an ASCII line over a UART TX pin (8N1). The block converts both bytes to three decimal digits, holds one pending sample while a frame is in flight, and returns to idle with the line held high.

---
 rtl/dht11_uart_report.sv | 179 +++++++++++++++++
 tb/tb_dht11_uart_report.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_uart_report.sv
`default_nettype none
// dht11_uart_report: latches DHT11 samples and sends them as "H=hhh T=ttt\r\n" over an 8N1 UART.
// Optional feature macro DHT_REPORT_UNITS_EN appends '%' and 'C' (15-byte frame "H=hhh% T=tttC\r\n").
module dht11_uart_report #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [7:0] humidity,
    input  logic [7:0] temperature,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
`ifdef DHT_REPORT_UNITS_EN
    localparam logic [3:0] LAST_BYTE = 4'd14;
`else
    localparam logic [3:0] LAST_BYTE = 4'd12;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [3:0]       byte_idx_q;
    logic [7:0]       hum_q, temp_q;
    logic [7:0]       pend_hum_q, pend_temp_q;
    logic             pend_vld_q;
    logic             tx_q, busy_q, overrun_q;

    logic [7:0]       frame_byte;
    logic             last_tick, frame_done, start_frame, load_drop;
    logic [7:0]       load_hum, load_temp;

    // pos: 2 = hundreds, 1 = tens, 0 = ones
    function automatic logic [7:0] ascii_digit(input logic [7:0] v, input logic [1:0] pos);
        logic [7:0] d;
        case (pos)
            2'd2:    d = v / 8'd100;
            2'd1:    d = (v % 8'd100) / 8'd10;
            default: d = v % 8'd10;
        endcase
        return 8'h30 + d;
    endfunction

    always_comb begin
        frame_byte = 8'h0A;
        case (byte_idx_q)
            4'd0:    frame_byte = 8'h48;
            4'd1:    frame_byte = 8'h3D;
            4'd2:    frame_byte = ascii_digit(hum_q, 2'd2);
            4'd3:    frame_byte = ascii_digit(hum_q, 2'd1);
            4'd4:    frame_byte = ascii_digit(hum_q, 2'd0);
`ifdef DHT_REPORT_UNITS_EN
            4'd5:    frame_byte = 8'h25;
            4'd6:    frame_byte = 8'h20;
            4'd7:    frame_byte = 8'h54;
            4'd8:    frame_byte = 8'h3D;
            4'd9:    frame_byte = ascii_digit(temp_q, 2'd2);
            4'd10:   frame_byte = ascii_digit(temp_q, 2'd1);
            4'd11:   frame_byte = ascii_digit(temp_q, 2'd0);
            4'd12:   frame_byte = 8'h43;
            4'd13:   frame_byte = 8'h0D;
            4'd14:   frame_byte = 8'h0A;
`else
            4'd5:    frame_byte = 8'h20;
            4'd6:    frame_byte = 8'h54;
            4'd7:    frame_byte = 8'h3D;
            4'd8:    frame_byte = ascii_digit(temp_q, 2'd2);
            4'd9:    frame_byte = ascii_digit(temp_q, 2'd1);
            4'd10:   frame_byte = ascii_digit(temp_q, 2'd0);
            4'd11:   frame_byte = 8'h0D;
            4'd12:   frame_byte = 8'h0A;
`endif
            default: frame_byte = 8'h0A;
        endcase
    end

    assign last_tick   = (cnt_q == CNT_LAST);
    assign frame_done  = (state_q == S_STOP) && last_tick && (byte_idx_q == LAST_BYTE);
    assign start_frame = ((state_q == S_IDLE) || frame_done) && (data_valid || pend_vld_q);
    // A live strobe always beats the pending entry; the displaced entry counts as an overrun.
    assign load_hum    = data_valid ? humidity    : pend_hum_q;
    assign load_temp   = data_valid ? temperature : pend_temp_q;
    assign load_drop   = data_valid && pend_vld_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            byte_idx_q  <= 4'd0;
            hum_q       <= 8'd0;
            temp_q      <= 8'd0;
            pend_hum_q  <= 8'd0;
            pend_temp_q <= 8'd0;
            pend_vld_q  <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (data_valid && busy_q && !frame_done) begin
                pend_hum_q  <= humidity;
                pend_temp_q <= temperature;
                pend_vld_q  <= 1'b1;
                overrun_q   <= pend_vld_q;
            end
            if (state_q != S_IDLE) begin
                cnt_q <= last_tick ? '0 : cnt_q + CNT_W'(1);
            end

            case (state_q)
                S_IDLE: ;
                S_START: begin
                    if (last_tick) begin
                        state_q   <= S_DATA;
                        bit_idx_q <= 3'd0;
                        tx_q      <= frame_byte[0];
                    end
                end
                S_DATA: begin
                    if (last_tick) begin
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= frame_byte[bit_idx_q + 3'd1];
                        end
                    end
                end
                S_STOP: begin
                    if (last_tick) begin
                        if (byte_idx_q != LAST_BYTE) begin
                            byte_idx_q <= byte_idx_q + 4'd1;
                            state_q    <= S_START;
                            tx_q       <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Overrides the idle/stop handling above so frames can run back-to-back.
            if (start_frame) begin
                hum_q      <= load_hum;
                temp_q     <= load_temp;
                pend_vld_q <= 1'b0;
                overrun_q  <= load_drop;
                byte_idx_q <= 4'd0;
                cnt_q      <= '0;
                tx_q       <= 1'b0;
                busy_q     <= 1'b1;
                state_q    <= S_START;
            end
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dht11_uart_report.sv
`timescale 1ns/1ps
`default_nettype none
// tb_dht11_uart_report: randomized self-checking bench; decodes tx as a UART receiver and
// compares against frames formatted from the sample values.
module tb_dht11_uart_report;
    localparam int DIV = 10;
`ifdef DHT_REPORT_UNITS_EN
    localparam int FRAME_LEN = 15;
`else
    localparam int FRAME_LEN = 13;
`endif
    localparam int FRAME_CYC = FRAME_LEN * 10 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_valid = 1'b0;
    logic [7:0] humidity = 8'd0;
    logic [7:0] temperature = 8'd0;
    logic       tx, busy, overrun;

    int checks = 0;
    int errors = 0;

    dht11_uart_report #(.CLK_HZ(1000), .BAUD(100)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_valid  (data_valid),
        .humidity    (humidity),
        .temperature (temperature),
        .tx          (tx),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    function automatic string frame_text(int h, int t);
`ifdef DHT_REPORT_UNITS_EN
        return $sformatf("H=%03d%% T=%03dC\r\n", h, t);
`else
        return $sformatf("H=%03d T=%03d\r\n", h, t);
`endif
    endfunction

    // Line monitor: UART receiver sampling mid-bit, plus busy/overrun statistics.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = 8'd0;
    bit         rx_act = 1'b0;
    int         rx_cnt = 0;
    int         frm_err = 0;
    int         busy_cnt = 0;
    int         busy_falls = 0;
    int         ov_cnt = 0;
    bit         busy_prev = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            rx_act    = 1'b0;
            busy_prev = 1'b0;
        end else begin
            if (busy === 1'b1) busy_cnt++;
            if (busy_prev && busy === 1'b0) busy_falls++;
            busy_prev = (busy === 1'b1);
            if (overrun === 1'b1) ov_cnt++;
            if (!rx_act) begin
                if (tx === 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
            end
            if (rx_act && (rx_cnt % DIV) == DIV / 2) begin
                if (rx_cnt / DIV == 0) begin
                    if (tx !== 1'b0) frm_err++;
                end else if (rx_cnt / DIV <= 8) begin
                    rx_sh[rx_cnt / DIV - 1] = tx;
                end else begin
                    if (tx !== 1'b1) frm_err++;
                    rx_q.push_back(rx_sh);
                    rx_act = 1'b0;
                end
            end
        end
    end

    task automatic clear_mon();
        rx_q.delete();
        busy_cnt   = 0;
        busy_falls = 0;
        ov_cnt     = 0;
        frm_err    = 0;
    endtask

    task automatic strobe(input int h, input int t);
        @(negedge clk);
        data_valid  = 1'b1;
        humidity    = 8'(h);
        temperature = 8'(t);
        @(negedge clk);
        data_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, bound);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_frames(input string name, input string exp);
        int bad = -1;
        checks++;
        if (rx_q.size() != exp.len()) begin
            errors++;
            $display("FAIL %s_len: got %0d bytes, required %0d", name, rx_q.size(), exp.len());
        end
        for (int i = 0; i < rx_q.size() && i < exp.len(); i++) begin
            if (bad < 0 && rx_q[i] !== 8'(exp[i])) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_byte: index %0d got %02h, required %02h", name, bad, rx_q[bad], 8'(exp[bad]));
        end
        checks++;
        if (frm_err != 0) begin
            errors++;
            $display("FAIL %s_framing: %0d bad start/stop bits, required 0", name, frm_err);
        end
    endtask

    task automatic check_stats(input string name, input int exp_busy, input int exp_ov);
        checks++;
        if (busy_cnt != exp_busy) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d, required %0d", name, busy_cnt, exp_busy);
        end
        checks++;
        if (ov_cnt != exp_ov) begin
            errors++;
            $display("FAIL %s_overrun: got %0d pulses, required %0d", name, ov_cnt, exp_ov);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, busy, overrun} !== 3'b100) begin
            errors++;
            $display("FAIL reset_outputs: tx/busy/overrun=%b, required 100", {tx, busy, overrun});
        end
        reset = 1'b0;
        clear_mon();
        repeat (30) @(negedge clk);
        checks++;
        if (rx_q.size() != 0 || busy_cnt != 0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: bytes=%0d busy_cycles=%0d tx=%b, required 0/0/1", rx_q.size(), busy_cnt, tx);
        end
    endtask

    task automatic test_basic();
        clear_mon();
        strobe(45, 23);
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_start: tx=%b busy=%b, required tx=0 busy=1", tx, busy);
        end
        wait_idle("basic", 2 * FRAME_CYC);
        check_frames("basic", frame_text(45, 23));
        check_stats("basic", FRAME_CYC, 0);
    endtask

    task automatic test_boundaries();
        int hv[3] = '{0, 99, 255};
        int tv[3] = '{9, 100, 200};
        for (int k = 0; k < 3; k++) begin
            clear_mon();
            strobe(hv[k], tv[k]);
            wait_idle("boundary", 2 * FRAME_CYC);
            check_frames($sformatf("boundary%0d", k), frame_text(hv[k], tv[k]));
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            int h = $urandom_range(0, 255);
            int t = $urandom_range(0, 255);
            clear_mon();
            strobe(h, t);
            // Inputs wander after the strobe; the frame must still show the latched sample.
            @(negedge clk);
            humidity    = 8'($urandom);
            temperature = 8'($urandom);
            wait_idle("random", 2 * FRAME_CYC);
            check_frames($sformatf("random%0d", k), frame_text(h, t));
            check_stats($sformatf("random%0d", k), FRAME_CYC, 0);
        end
    endtask

    task automatic test_pending();
        int h = $urandom_range(0, 255);
        int t = $urandom_range(0, 255);
        clear_mon();
        strobe(h, t);
        repeat (300) @(negedge clk);
        strobe(10, 20);
        wait_idle("pending", 3 * FRAME_CYC);
        check_frames("pending", {frame_text(h, t), frame_text(10, 20)});
        check_stats("pending", 2 * FRAME_CYC, 0);
        checks++;
        if (busy_falls != 1) begin
            errors++;
            $display("FAIL pending_busy_falls: got %0d, required 1", busy_falls);
        end
    endtask

    task automatic test_overrun();
        clear_mon();
        strobe(1, 1);
        repeat (100) @(negedge clk);
        strobe(2, 2);
        repeat (100) @(negedge clk);
        strobe(3, 3);
        wait_idle("overrun", 3 * FRAME_CYC);
        check_frames("overrun", {frame_text(1, 1), frame_text(3, 3)});
        check_stats("overrun", 2 * FRAME_CYC, 1);
    endtask

    task automatic test_back_to_back();
        int ha = $urandom_range(0, 255);
        int hb = $urandom_range(0, 255);
        int hp = $urandom_range(0, 255);
        // Strobe lands exactly in the last cycle of the final stop bit.
        clear_mon();
        strobe(ha, hb);
        repeat (FRAME_CYC - 2) @(negedge clk);
        strobe(hb, ha);
        wait_idle("b2b", 3 * FRAME_CYC);
        check_frames("b2b", {frame_text(ha, hb), frame_text(hb, ha)});
        check_stats("b2b", 2 * FRAME_CYC, 0);
        checks++;
        if (busy_falls != 1) begin
            errors++;
            $display("FAIL b2b_busy_falls: got %0d, required 1", busy_falls);
        end
        // Same edge case with the pending entry already full: the strobe wins.
        clear_mon();
        strobe(ha, ha);
        repeat (200) @(negedge clk);
        strobe(hp, hp);
        repeat (FRAME_CYC - 2 - 202) @(negedge clk);
        strobe(hb, hb);
        wait_idle("b2b_full", 3 * FRAME_CYC);
        check_frames("b2b_full", {frame_text(ha, ha), frame_text(hb, hb)});
        check_stats("b2b_full", 2 * FRAME_CYC, 1);
    endtask

    task automatic test_reset_mid();
        int h = $urandom_range(0, 255);
        int t = $urandom_range(0, 255);
        clear_mon();
        strobe(h, t);
        repeat (5 * 10 * DIV + 50) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({tx, busy, overrun} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid_outputs: tx/busy/overrun=%b, required 100", {tx, busy, overrun});
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_mon();
        repeat (50) @(negedge clk);
        checks++;
        if (rx_q.size() != 0 || busy_cnt != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: bytes=%0d busy_cycles=%0d, required 0/0", rx_q.size(), busy_cnt);
        end
        clear_mon();
        strobe(t, h);
        wait_idle("reset_mid", 2 * FRAME_CYC);
        check_frames("reset_mid_after", frame_text(t, h));
        check_stats("reset_mid_after", FRAME_CYC, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_random();
        test_pending();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
